// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG run-length coder: zigzag ROM, FSM states
// and the packed symbol record handed to the entropy coder.
package jpeg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      EVAL,
      ZRL,
      EMIT
   } state_t;

   typedef struct packed {
      logic        dc;
      logic [1:0]  comp;
      logic [3:0]  run;
      logic [3:0]  size;
      logic [10:0] amp;
   } sym_t;

   // Zigzag scan position -> natural row-major index of an 8x8 block.
   localparam logic [5:0] ZZ_ROM [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   function automatic logic [5:0] zz_addr(input logic [5:0] k);
      return ZZ_ROM[k];
   endfunction

   function automatic sym_t mk_sym(input logic dc, input logic [1:0] comp,
                                   input logic [3:0] run, input logic [3:0] size,
                                   input logic [10:0] amp);
      sym_t s;
      s.dc   = dc;
      s.comp = comp;
      s.run  = run;
      s.size = size;
      s.amp  = amp;
      return s;
   endfunction

endpackage

// File: rtl/jpeg_amp_enc.sv
// Magnitude category and amplitude bits of a saturated signed value.
// Negative values use the one's-complement form (v-1 masked to size bits).
module jpeg_amp_enc (
   input  logic signed [11:0] val_i,
   output logic [3:0]         size_o,
   output logic [10:0]        amp_o
);

   logic [11:0] mag;
   logic [11:0] adj;
   logic [10:0] mask;

   always_comb begin
      mag    = val_i[11] ? 12'(-val_i) : val_i;
      size_o = '0;
      for (int i = 0; i < 12; i++) begin
         if (mag[i]) size_o = 4'(i + 1);
      end
      mask  = 11'((12'd1 << size_o) - 12'd1);
      adj   = val_i[11] ? 12'(val_i - 12'sd1) : val_i;
      amp_o = 11'(adj) & mask;
   end

endmodule

// File: rtl/jpeg_rle.sv
// Zigzag run-length coder for one quantized 8x8 block: DC difference symbol,
// AC (run,size,amp) symbols with ZRL splitting, and EOB.
module jpeg_rle
   import jpeg_pkg::*;
#(
   parameter int CW = 16,
   parameter int AW = 6
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [1:0]    comp_i,
   input  logic          clr_pred_i,
   output logic [AW-1:0] mem_addr_o,
   input  logic [CW-1:0] mem_data_i,
   output logic          sym_valid_o,
   input  logic          sym_ready_i,
   output logic          sym_dc_o,
   output logic [1:0]    sym_comp_o,
   output logic [3:0]    sym_run_o,
   output logic [3:0]    sym_size_o,
   output logic [10:0]   sym_amp_o,
   output logic          busy_o,
   output logic          done_o
);

   localparam logic signed [CW-1:0] SAT_MAX = CW'(1023);
   localparam logic signed [CW-1:0] SAT_MIN = -SAT_MAX;

   state_t             state;
   logic [5:0]         k;
   logic [5:0]         run;
   logic [1:0]         comp;
   logic [AW-1:0]      mem_addr;
   sym_t               sym_q;
   logic               sym_valid;
   logic               busy;
   logic               done;
   logic signed [11:0] pend;
   logic signed [11:0] dc_coef;
   logic signed [11:0] pred [3];

   logic signed [11:0] sat;
   logic signed [11:0] pred_cur;
   logic signed [11:0] diff;
   logic signed [11:0] enc_in;
   logic [3:0]         enc_size;
   logic [10:0]        enc_amp;

   // Clamp the raw coefficient first; the single encoder then sees either the
   // DC difference, the current AC value, or the AC value parked behind ZRLs.
   always_comb begin
      if ($signed(mem_data_i) > SAT_MAX)      sat = 12'sd1023;
      else if ($signed(mem_data_i) < SAT_MIN) sat = -12'sd1023;
      else                                    sat = 12'(mem_data_i);
      case (comp)
         2'd1:    pred_cur = pred[1];
         2'd2:    pred_cur = pred[2];
         default: pred_cur = pred[0];
      endcase
      diff = sat - pred_cur;
      if (state == ZRL)  enc_in = pend;
      else if (k == 6'd0) enc_in = diff;
      else               enc_in = sat;
   end

   jpeg_amp_enc u_amp_enc (
      .val_i  (enc_in),
      .size_o (enc_size),
      .amp_o  (enc_amp)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         k         <= '0;
         run       <= '0;
         comp      <= '0;
         mem_addr  <= '0;
         sym_q     <= '0;
         sym_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pend      <= '0;
         dc_coef   <= '0;
         for (int i = 0; i < 3; i++) pred[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (clr_pred_i) begin
                  for (int i = 0; i < 3; i++) pred[i] <= '0;
               end
               if (start_i) begin
                  comp     <= (comp_i == 2'd3) ? 2'd0 : comp_i;
                  k        <= '0;
                  run      <= '0;
                  mem_addr <= AW'(zz_addr(6'd0));
                  busy     <= 1'b1;
                  state    <= ADDR;
               end
            end
            ADDR: state <= EVAL;
            EVAL: begin
               if (k == 6'd0) begin
                  sym_q     <= mk_sym(1'b1, comp, 4'd0, enc_size, enc_amp);
                  dc_coef   <= sat;
                  sym_valid <= 1'b1;
                  state     <= EMIT;
               end else if (sat == 12'sd0) begin
                  run <= run + 6'd1;
                  if (k != 6'd63) begin
                     k        <= k + 6'd1;
                     mem_addr <= AW'(zz_addr(k + 6'd1));
                     state    <= ADDR;
                  end else begin
                     sym_q     <= mk_sym(1'b0, comp, 4'd0, 4'd0, 11'd0);
                     sym_valid <= 1'b1;
                     state     <= EMIT;
                  end
               end else if (run >= 6'd16) begin
                  pend      <= sat;
                  sym_q     <= mk_sym(1'b0, comp, 4'd15, 4'd0, 11'd0);
                  sym_valid <= 1'b1;
                  state     <= ZRL;
               end else begin
                  sym_q     <= mk_sym(1'b0, comp, run[3:0], enc_size, enc_amp);
                  run       <= '0;
                  sym_valid <= 1'b1;
                  state     <= EMIT;
               end
            end
            // Subtracting 16 leaves the low nibble unchanged, so run[3:0] is
            // already the residual run once fewer than 32 zeros remain.
            ZRL: begin
               if (sym_ready_i) begin
                  if (run < 6'd32) begin
                     sym_q <= mk_sym(1'b0, comp, run[3:0], enc_size, enc_amp);
                     run   <= '0;
                     state <= EMIT;
                  end else begin
                     run <= run - 6'd16;
                  end
               end
            end
            EMIT: begin
               if (sym_ready_i) begin
                  sym_valid <= 1'b0;
                  if (k == 6'd0) begin
                     case (comp)
                        2'd1:    pred[1] <= dc_coef;
                        2'd2:    pred[2] <= dc_coef;
                        default: pred[0] <= dc_coef;
                     endcase
                  end
                  if (k == 6'd63) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     k        <= k + 6'd1;
                     mem_addr <= AW'(zz_addr(k + 6'd1));
                     state    <= ADDR;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_addr_o  = mem_addr;
   assign sym_valid_o = sym_valid;
   assign sym_dc_o    = sym_q.dc;
   assign sym_comp_o  = sym_q.comp;
   assign sym_run_o   = sym_q.run;
   assign sym_size_o  = sym_q.size;
   assign sym_amp_o   = sym_q.amp;
   assign busy_o      = busy;
   assign done_o      = done;

endmodule
